// File: rtl/sensor_link_pkg.sv
// Shared types and constants for the host side of the sensor byte-stream link.
package sensor_link_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TX,
    ST_RX,
    ST_DONE
  } state_e;

  localparam int REQ_BYTES = 7;
  localparam int RSP_BYTES = 6;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // Bit positions inside the response flags byte (byte 5)
  localparam int FLAG_CRC_OK          = 0;
  localparam int FLAG_ERR_CRC         = 1;
  localparam int FLAG_ERR_VOTER       = 2;
  localparam int FLAG_ERR_UNCORR      = 3;

endpackage

// File: rtl/crc8_byte.sv
// One-byte CRC-8 step: MSB-first, no reflection, no final XOR.
module crc8_byte
  import sensor_link_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] data,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  always_comb begin
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/sensor_link_host.sv
// Host endpoint: sends a 7-byte CRC-protected request, then collects and
// decodes the 6-byte response with an RX timeout.
module sensor_link_host
  import sensor_link_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter bit RX_READY_GAP   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [47:0] req_sensor,
  input  logic        req_corrupt,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [7:0]  rx_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_psi,
  output logic [15:0] rsp_theta,
  output logic [7:0]  rsp_flags,
  output logic        rsp_crc_ok,
  output logic        rsp_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e                           state_q, state_d;
  logic [REQ_BYTES-2:0][7:0]        sensor_q, sensor_d;
  logic                             corrupt_q, corrupt_d;
  logic [2:0]                       tx_idx_q, tx_idx_d;
  logic [7:0]                       tx_crc_q, tx_crc_d;
  logic [2:0]                       rx_idx_q, rx_idx_d;
  logic [7:0]                       rx_crc_q, rx_crc_d;
  logic [RSP_BYTES-1:0][7:0]        rx_buf_q, rx_buf_d;
  logic [TW-1:0]                    timer_q, timer_d;
  logic                             gap_q, gap_d;
  logic                             crc_ok_q, crc_ok_d;
  logic                             timeout_q, timeout_d;

  logic [7:0] tx_byte, tx_crc_next, rx_crc_next;

  // Byte 6 of the request is the running CRC, optionally inverted for fault injection
  assign tx_byte = (tx_idx_q < 3'(REQ_BYTES - 1)) ? sensor_q[tx_idx_q]
                                                  : (tx_crc_q ^ {8{corrupt_q}});

  crc8_byte u_tx_crc (.crc_in(tx_crc_q), .data(tx_byte), .crc_out(tx_crc_next));
  crc8_byte u_rx_crc (.crc_in(rx_crc_q), .data(rx_data), .crc_out(rx_crc_next));

  always_comb begin
    state_d   = state_q;
    sensor_d  = sensor_q;
    corrupt_d = corrupt_q;
    tx_idx_d  = tx_idx_q;
    tx_crc_d  = tx_crc_q;
    rx_idx_d  = rx_idx_q;
    rx_crc_d  = rx_crc_q;
    rx_buf_d  = rx_buf_q;
    timer_d   = timer_q;
    gap_d     = gap_q;
    crc_ok_d  = crc_ok_q;
    timeout_d = timeout_q;
    req_ready = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    rx_ready  = 1'b0;
    rsp_valid = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          sensor_d  = req_sensor;
          corrupt_d = req_corrupt;
          tx_crc_d  = 8'h00;
          tx_idx_d  = 3'd0;
          state_d   = ST_TX;
        end
      end
      ST_TX: begin
        tx_valid = 1'b1;
        tx_data  = tx_byte;
        if (tx_ready) begin
          if (tx_idx_q < 3'(REQ_BYTES - 1)) tx_crc_d = tx_crc_next;
          tx_idx_d = tx_idx_q + 3'd1;
          if (tx_idx_q == 3'(REQ_BYTES - 1)) begin
            rx_buf_d = '0;
            rx_crc_d = 8'h00;
            rx_idx_d = 3'd0;
            timer_d  = '0;
            gap_d    = 1'b0;
            state_d  = ST_RX;
          end
        end
      end
      ST_RX: begin
        rx_ready = !(RX_READY_GAP && gap_q);
        timer_d  = timer_q + TW'(1);
        gap_d    = 1'b0;
        if (rx_valid && rx_ready) begin
          rx_buf_d[rx_idx_q] = rx_data;
          gap_d              = 1'b1;
          if (rx_idx_q < 3'd4) rx_crc_d = rx_crc_next;
          rx_idx_d = rx_idx_q + 3'd1;
        end
        // A final byte landing on the expiry cycle takes priority over the timeout
        if (rx_valid && rx_ready && rx_idx_q == 3'(RSP_BYTES - 1)) begin
          crc_ok_d  = (rx_buf_q[4] == rx_crc_q);
          timeout_d = 1'b0;
          state_d   = ST_DONE;
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          crc_ok_d  = 1'b0;
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sensor_q  <= '0;
      corrupt_q <= 1'b0;
      tx_idx_q  <= 3'd0;
      tx_crc_q  <= 8'h00;
      rx_idx_q  <= 3'd0;
      rx_crc_q  <= 8'h00;
      rx_buf_q  <= '0;
      timer_q   <= '0;
      gap_q     <= 1'b0;
      crc_ok_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sensor_q  <= sensor_d;
      corrupt_q <= corrupt_d;
      tx_idx_q  <= tx_idx_d;
      tx_crc_q  <= tx_crc_d;
      rx_idx_q  <= rx_idx_d;
      rx_crc_q  <= rx_crc_d;
      rx_buf_q  <= rx_buf_d;
      timer_q   <= timer_d;
      gap_q     <= gap_d;
      crc_ok_q  <= crc_ok_d;
      timeout_q <= timeout_d;
    end
  end

  assign rsp_psi     = {rx_buf_q[0], rx_buf_q[1]};
  assign rsp_theta   = {rx_buf_q[2], rx_buf_q[3]};
  assign rsp_flags   = rx_buf_q[5];
  assign rsp_crc_ok  = crc_ok_q;
  assign rsp_timeout = timeout_q;

endmodule

// File: doc/sensor_link_host.md
# sensor_link_host

Host-side endpoint of the sensor byte-stream link. Accepts one parallel sample of six signed magnetometer bytes, serialises it as a 7-byte request frame (six data bytes plus CRC-8), then receives and decodes the 6-byte response frame (psi, theta, CRC-8, flags). Sits on the test/host side of the chip's `in_*`/`out_*` byte ports: `tx_*` drives the chip input, and `rx_*` takes the chip output.

## Interface
- `TIMEOUT_CYCLES`, default 1024: maximum number of cycles spent in RX before the transaction is abandoned.
- `RX_READY_GAP`, default 1: when set to 1, `rx_ready` is held low for exactly one cycle after every accepted response byte.
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid` / `req_ready`  in/out  1  request handshake.
- `req_sensor`  in  48  bytes B+X..B−Z; byte k is bits [8k+7:8k] and is sent k-th.
- `req_corrupt`  in  1  when 1, the transmitted CRC byte is inverted (XOR 0xFF).
- `tx_valid`  out  1, `tx_ready`  in  1, `tx_data`  out  8: request byte stream.
- `rx_valid`  in  1, `rx_ready`  out  1, `rx_data`  in  8: response byte stream.
- `rsp_valid` / `rsp_ready`  out/in  1  result handshake.
- `rsp_psi`, `rsp_theta`  out  16  signed results; the first-received byte of each is the high byte.
- `rsp_flags`  out  8  response byte 5, passed through unmodified.
- `rsp_crc_ok`  out  1  received byte 4 equals the CRC over response bytes 0–3.
- `rsp_timeout`  out  1  the response was incomplete when the timeout fired.

## Operation
- CRC-8 definition: polynomial 0x07, init 0x00, MSB-first, no reflection, no final XOR, one byte per cycle.
- States: IDLE, TX, RX, DONE.
- IDLE
  - `req_ready`=1.
  - On `req_valid`: latch `req_sensor` and `req_corrupt`, clear the tx CRC and `tx_idx`, go to TX.
- TX
  - `tx_valid`=1.
  - `tx_data` is a combinational mux: the latched byte for `tx_idx` 0–5, or `crc ^ {8{corrupt}}` for `tx_idx` 6.
  - On each `tx_valid && tx_ready` while `tx_idx`<6, update the CRC with `tx_data`.
  - After the 7th accepted byte, go to RX. Entering RX clears the rx buffer to zero, the rx CRC, `rx_idx` and the timer.
- RX
  - `rx_ready`=1, except in the cycle immediately after an accepted byte when `RX_READY_GAP`=1.
  - On each accepted byte, store it at `rx_idx`. Bytes 0–3 update the rx CRC.
  - After the 6th accepted byte, go to DONE with `rsp_crc_ok` = (byte4 == rx CRC) and `rsp_timeout`=0.
  - The timer increments every RX cycle. When it reaches `TIMEOUT_CYCLES`−1 without completion, go to DONE with `rsp_timeout`=1 and `rsp_crc_ok`=0.
  - In the timeout case, fields are built from the bytes received so far; unreceived bytes are 0.
- DONE
  - `rsp_valid`=1; all `rsp_*` fields are stable.
  - On `rsp_ready`, go to IDLE.
- `tx_valid`, `rx_ready` and `req_ready` are all 0 outside their respective states.

## Timing
- Reset values: state IDLE, every counter 0; all outputs 0 except `req_ready`=1. `tx_data` is 0 in IDLE.
- Request acceptance to first `tx_valid`: 1 cycle.
- TX throughput: with `tx_ready` held high, TX occupies exactly 7 cycles.
- Last RX byte accepted to `rsp_valid`: 1 cycle.
- `rsp_valid` to the next `req_ready`: 1 cycle after the `rsp_ready` handshake.
- `tx_data`/`tx_valid` stay stable while `tx_ready`=0.
- Final byte accepted in the same cycle the timer expires: the byte wins, `rsp_timeout`=0.
- `rx_valid` while not in RX: ignored, nothing stored.
- `rst` asserted in any state: everything returns to reset values on the next edge, and any partial frame is discarded.
- Mid-frame back-pressure (`tx_ready` low for any number of cycles): no duplicated or skipped bytes.

## Structure
- Package `sensor_link_pkg` holds:
  - the state enum;
  - `REQ_BYTES`=7 and `RSP_BYTES`=6;
  - `CRC8_POLY`=8'h07;
  - the flags bit positions: 0 crc_ok, 1 error_crc, 2 error_voter, 3 error_uncorrectable.
- One sub-module: `crc8_byte`, combinational (`crc_in`, `data` → `crc_out`). It is instantiated twice, once for tx and once for rx.

## Test plan
- All-zero sample, `tx_ready`=1 → 7 consecutive bytes 00 00 00 00 00 00 00, then RX entered.
- Sample bytes 01 00 00 00 00 00 → tx CRC byte 0x29. With `req_corrupt`=1 → CRC byte 0xD6.
- Response 12 34 FF FE c 01, with c the correct CRC → `rsp_psi`=0x1234, `rsp_theta`=−2, `rsp_flags`=0x01, `rsp_crc_ok`=1.
- Same response with byte 4 flipped → `rsp_crc_ok`=0, other fields unchanged.
- Responder that repeats each byte for one extra valid cycle, `RX_READY_GAP`=1 → no duplicates, correct decode.
- `TIMEOUT_CYCLES`=16, only 3 bytes sent → `rsp_timeout`=1 after 16 RX cycles and `rsp_theta`=0. Separately, `rst` pulsed mid-TX → bench checks `tx_valid`=0 and `req_ready`=1 the next cycle.
